// File: rtl/gcn_pkg.sv
// Shared types for the GCN MAC tile: row vectors, job command and scheduler state.
package gcn_pkg;
  localparam int BIDX_W    = 5;
  localparam int CMD_ROW_W = 5;
  localparam int CMD_KT_W  = 6;

  typedef logic [3:0][15:0] vec4x16_t;

  typedef struct packed {
    logic [CMD_ROW_W-1:0] rows;
    logic [CMD_KT_W-1:0]  ktiles;
    logic [BIDX_W-1:0]    bidx;
  } mac_cmd_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_e;

  // A job must fit the psum buffer and must not sweep past the last weight index.
  function automatic logic cmd_illegal(mac_cmd_t cmd, int max_rows);
    return (cmd.rows == '0) || (int'(cmd.rows) > max_rows) || (cmd.ktiles == '0) ||
           ((int'(cmd.bidx) + int'(cmd.ktiles)) > (1 << BIDX_W));
  endfunction
endpackage

// File: rtl/res_fifo2.sv
// Two-entry result FIFO (row vector plus last flag) with occupancy count.
module res_fifo2
  import gcn_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  vec4x16_t   push_data,
  input  logic       push_last,
  input  logic       pop,
  output logic [1:0] count,
  output logic       valid,
  output vec4x16_t   head_data,
  output logic       head_last
);
  vec4x16_t   data_reg [2];
  logic       last_reg [2];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       do_pop;
  logic       do_push;

  assign do_pop  = pop && (count_reg != 2'd0);
  assign do_push = push && ((count_reg != 2'd2) || do_pop);

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clock) begin
      if (reset) begin
        data_reg[gi] <= '0;
        last_reg[gi] <= 1'b0;
      end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
        data_reg[gi] <= push_data;
        last_reg[gi] <= push_last;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count     = count_reg;
  assign valid     = (count_reg != 2'd0);
  assign head_data = valid ? data_reg[rd_ptr_reg] : '0;
  assign head_last = valid ? last_reg[rd_ptr_reg] : 1'b0;
endmodule

// File: rtl/mac4x4_sched.sv
// Job sequencer for one mac4x4 tile: streams A rows over T weight passes,
// chains partial sums through a local buffer and emits the final rows.
module mac4x4_sched
  import gcn_pkg::*;
#(
  parameter int MAX_ROWS = 16,
  parameter int ROW_W    = CMD_ROW_W,
  parameter int KT_W     = CMD_KT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ROW_W-1:0]  cmd_rows,
  input  logic [KT_W-1:0]   cmd_ktiles,
  input  logic [BIDX_W-1:0] cmd_bidx,
  output logic              cmd_err,
  input  logic              a_valid,
  output logic              a_ready,
  input  vec4x16_t          a_data,
  output logic              mac_en,
  output vec4x16_t          mac_a,
  output logic [BIDX_W-1:0] mac_bidx,
  output vec4x16_t          mac_c,
  input  logic              mac_r_v,
  input  vec4x16_t          mac_r,
  output logic              res_valid,
  input  logic              res_ready,
  output vec4x16_t          res_data,
  output logic              res_last,
  output logic              busy
);
  localparam int IDX_W = $clog2(MAX_ROWS);

  sched_state_e     state_reg;
  mac_cmd_t         cmd_reg;
  mac_cmd_t         cmd_in;
  logic [ROW_W-1:0] row_reg;
  logic [KT_W-1:0]  pass_reg;
  logic             tag_valid_reg;
  logic             final_d_reg;
  logic [ROW_W-1:0] row_d_reg;
  logic             cmd_err_reg;
  vec4x16_t         psum [MAX_ROWS];

  logic       final_pass, last_row, inflight_final, can_issue, issue;
  logic       wb_valid, wb_psum, wb_final, bypass, pop_last;
  logic [1:0] fifo_count;
  vec4x16_t   psum_rd;

  assign cmd_in = '{rows: cmd_rows, ktiles: cmd_ktiles, bidx: cmd_bidx};

  assign final_pass     = (pass_reg == cmd_reg.ktiles - 1'b1);
  assign last_row       = (row_reg == cmd_reg.rows - 1'b1);
  assign inflight_final = tag_valid_reg && final_d_reg;
  // Final-pass issues reserve a FIFO slot so a stalled consumer never drops a result.
  assign can_issue      = !final_pass || ((fifo_count + {1'b0, inflight_final}) < 2'd2);
  assign issue          = (state_reg == RUN) && a_valid && can_issue;

  assign wb_valid = mac_r_v && tag_valid_reg;
  assign wb_psum  = wb_valid && !final_d_reg;
  assign wb_final = wb_valid && final_d_reg;
  assign bypass   = wb_psum && (row_d_reg == row_reg);
  assign psum_rd  = psum[row_reg[IDX_W-1:0]];

  assign mac_en   = issue;
  assign a_ready  = issue;
  assign mac_a    = issue ? a_data : '0;
  assign mac_bidx = issue ? BIDX_W'(cmd_reg.bidx + pass_reg) : '0;
  assign mac_c    = (!issue || (pass_reg == '0)) ? '0 : (bypass ? mac_r : psum_rd);

  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign cmd_err   = cmd_err_reg;
  assign pop_last  = res_valid && res_ready && res_last;

  // Partial sums are only meaningful within a job, so the buffer has no reset.
  always_ff @(posedge clock) begin
    if (wb_psum) psum[row_d_reg[IDX_W-1:0]] <= mac_r;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      cmd_reg       <= '0;
      row_reg       <= '0;
      pass_reg      <= '0;
      tag_valid_reg <= 1'b0;
      final_d_reg   <= 1'b0;
      row_d_reg     <= '0;
      cmd_err_reg   <= 1'b0;
    end else begin
      cmd_err_reg   <= 1'b0;
      tag_valid_reg <= issue;
      if (issue) begin
        row_d_reg   <= row_reg;
        final_d_reg <= final_pass;
      end
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_illegal(cmd_in, MAX_ROWS)) begin
              cmd_err_reg <= 1'b1;
            end else begin
              cmd_reg   <= cmd_in;
              row_reg   <= '0;
              pass_reg  <= '0;
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            if (last_row) begin
              row_reg  <= '0;
              pass_reg <= pass_reg + 1'b1;
              if (final_pass) state_reg <= DRAIN;
            end else begin
              row_reg <= row_reg + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (pop_last) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  res_fifo2 u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wb_final),
    .push_data (mac_r),
    .push_last (row_d_reg == cmd_reg.rows - 1'b1),
    .pop       (res_ready),
    .count     (fifo_count),
    .valid     (res_valid),
    .head_data (res_data),
    .head_last (res_last)
  );
endmodule

// File: tb/tb_mac4x4_sched.sv
// Directed bench for mac4x4_sched with a behavioural mac4x4 stand-in and a reference model.
module tb_mac4x4_sched;
  import gcn_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_err;
  logic [4:0]  cmd_rows;
  logic [5:0]  cmd_ktiles;
  logic [4:0]  cmd_bidx;
  logic        a_valid, a_ready;
  vec4x16_t    a_data;
  logic        mac_en;
  vec4x16_t    mac_a, mac_c, mac_r;
  logic [4:0]  mac_bidx;
  logic        mac_r_v;
  logic        res_valid, res_ready, res_last;
  vec4x16_t    res_data;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int a_cnt = 0;
  int iss_n = 0;
  int res_n = 0;
  logic [4:0] iss_bidx [256];
  vec4x16_t   iss_c    [256];
  int         iss_cyc  [256];
  vec4x16_t   res_d    [256];
  logic       res_l    [256];
  int         res_cyc  [256];

  assign reset_n = ~reset;
  always #5 clock = ~clock;

  mac4x4_sched dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rows(cmd_rows),
    .cmd_ktiles(cmd_ktiles), .cmd_bidx(cmd_bidx), .cmd_err(cmd_err),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .mac_en(mac_en), .mac_a(mac_a), .mac_bidx(mac_bidx), .mac_c(mac_c),
    .mac_r_v(mac_r_v), .mac_r(mac_r),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .busy(busy)
  );

  // r[j] = c[j] + sum_i a[i] * W[b][i][j], W[b][i][j] = 3b + 5i + 7j + 1, 16-bit wrap
  function automatic vec4x16_t mac_model(vec4x16_t a, logic [4:0] b, vec4x16_t c);
    vec4x16_t r;
    logic [15:0] s;
    for (int j = 0; j < 4; j++) begin
      s = c[j];
      for (int i = 0; i < 4; i++) s = s + a[i] * (16'(b) * 16'd3 + 16'(i * 5 + j * 7 + 1));
      r[j] = s;
    end
    return r;
  endfunction

  function automatic vec4x16_t gen_a(int idx);
    vec4x16_t a;
    for (int i = 0; i < 4; i++) a[i] = 16'(idx * 4 + i + 1);
    return a;
  endfunction

  // Expected sum for row r after t passes of a job whose first A row was index a0.
  function automatic vec4x16_t expect_row(int a0, int n, int t, int base, int r);
    vec4x16_t acc = '0;
    for (int p = 0; p < t; p++) acc = mac_model(gen_a(a0 + p * n + r), 5'(base + p), acc);
    return acc;
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      mac_r_v <= 1'b0;
      mac_r   <= '0;
    end else begin
      mac_r_v <= mac_en;
      if (mac_en) mac_r <= mac_model(mac_a, mac_bidx, mac_c);
    end
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (a_valid && a_ready) a_cnt <= a_cnt + 1;
  end

  always_comb a_data = gen_a(a_cnt);

  always @(negedge clock) begin
    if (mac_en && iss_n < 256) begin
      iss_bidx[iss_n] = mac_bidx;
      iss_c[iss_n]    = mac_c;
      iss_cyc[iss_n]  = cyc;
      iss_n++;
    end
    if (res_valid && res_ready && res_n < 256) begin
      res_d[res_n]   = res_data;
      res_l[res_n]   = res_last;
      res_cyc[res_n] = cyc;
      res_n++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(int rows, int kt, int base);
    cmd_rows   = 5'(rows);
    cmd_ktiles = 6'(kt);
    cmd_bidx   = 5'(base);
    cmd_valid  = 1'b1;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(int max);
    int n = 0;
    while (busy === 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic check_results(string tag, int a0, int n, int t, int base, int rb);
    chk($sformatf("%s_nres", tag), 64'(res_n - rb), 64'(n));
    for (int r = 0; r < n; r++) begin
      chk($sformatf("%s_data%0d", tag, r), 64'(res_d[rb + r]), 64'(expect_row(a0, n, t, base, r)));
      chk($sformatf("%s_last%0d", tag, r), 64'(res_l[rb + r]), 64'(r == n - 1));
    end
  endtask

  initial begin
    int a0, ib, rb, n;
    cmd_valid = 1'b0; cmd_rows = '0; cmd_ktiles = '0; cmd_bidx = '0;
    a_valid = 1'b0; res_ready = 1'b1;
    reset = 1'b1;
    tick(); tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_mac_en",    64'(mac_en),    64'd0);
    chk("rst_cmd_err",   64'(cmd_err),   64'd0);
    chk("rst_res_data",  64'(res_data),  64'd0);
    reset = 1'b0;
    tick();

    // 1: single row, single pass, hand-computed result [110,180,250,320]
    a_valid = 1'b1;
    a0 = a_cnt; ib = iss_n; rb = res_n;
    run_cmd(1, 1, 0);
    chk("s1_busy", 64'(busy), 64'd1);
    wait_idle(40);
    chk("s1_niss",    64'(iss_n - ib), 64'd1);
    chk("s1_bidx",    64'(iss_bidx[ib]), 64'd0);
    chk("s1_c",       64'(iss_c[ib]), 64'd0);
    chk("s1_nres",    64'(res_n - rb), 64'd1);
    chk("s1_data",    64'(res_d[rb]), {16'd320, 16'd250, 16'd180, 16'd110});
    chk("s1_last",    64'(res_l[rb]), 64'd1);
    chk("s1_latency", 64'(res_cyc[rb] - iss_cyc[ib]), 64'd2);
    chk("s1_busydrop", 64'(cyc), 64'(res_cyc[rb] + 1));
    chk("s1_model",   64'(expect_row(a0, 1, 1, 0, 0)), {16'd320, 16'd250, 16'd180, 16'd110});

    // 2: N=4, T=3, base=7 with continuous A
    a0 = a_cnt; ib = iss_n; rb = res_n;
    run_cmd(4, 3, 7);
    wait_idle(100);
    chk("s2_niss", 64'(iss_n - ib), 64'd12);
    for (int k = 0; k < 12; k++)
      chk($sformatf("s2_bidx%0d", k), 64'(iss_bidx[ib + k]), 64'(7 + k / 4));
    check_results("s2", a0, 4, 3, 7, rb);

    // 3: N=1, T=4 exercises the writeback bypass back-to-back
    a0 = a_cnt; ib = iss_n; rb = res_n;
    run_cmd(1, 4, 2);
    wait_idle(60);
    chk("s3_niss", 64'(iss_n - ib), 64'd4);
    for (int p = 1; p < 4; p++) begin
      chk($sformatf("s3_gap%0d", p), 64'(iss_cyc[ib + p] - iss_cyc[ib + p - 1]), 64'd1);
      chk($sformatf("s3_c%0d", p), 64'(iss_c[ib + p]), 64'(expect_row(a0, 1, p, 2, 0)));
    end
    check_results("s3", a0, 1, 4, 2, rb);

    // 4: consumer stalled, issue must stop once two results are held
    a0 = a_cnt; ib = iss_n; rb = res_n;
    res_ready = 1'b0;
    run_cmd(8, 1, 5);
    repeat (20) tick();
    chk("s4_niss_stall", 64'(iss_n - ib), 64'd2);
    chk("s4_a_ready",    64'(a_ready),    64'd0);
    chk("s4_res_valid",  64'(res_valid),  64'd1);
    res_ready = 1'b1;
    wait_idle(100);
    chk("s4_niss", 64'(iss_n - ib), 64'd8);
    check_results("s4", a0, 8, 1, 5, rb);

    // 5: illegal commands are consumed and flagged, then a boundary-legal one
    ib = iss_n;
    run_cmd(0, 1, 0);
    chk("s5a_err",  64'(cmd_err), 64'd1);
    chk("s5a_busy", 64'(busy),    64'd0);
    tick();
    chk("s5a_err_pulse", 64'(cmd_err), 64'd0);
    run_cmd(1, 3, 30);
    chk("s5b_err",  64'(cmd_err), 64'd1);
    chk("s5b_busy", 64'(busy),    64'd0);
    tick();
    chk("s5b_err_pulse", 64'(cmd_err), 64'd0);
    run_cmd(17, 1, 0);
    chk("s5c_err", 64'(cmd_err), 64'd1);
    tick();
    chk("s5_no_mac", 64'(iss_n - ib), 64'd0);
    a0 = a_cnt; rb = res_n;
    run_cmd(1, 2, 30);
    chk("s5d_err",  64'(cmd_err), 64'd0);
    chk("s5d_busy", 64'(busy),    64'd1);
    wait_idle(40);
    check_results("s5d", a0, 1, 2, 30, rb);

    // 6: reset during the third pass, then a fresh job
    ib = iss_n;
    run_cmd(4, 3, 1);
    n = 0;
    while ((iss_n - ib) < 9 && n < 60) begin
      tick();
      n++;
    end
    chk("s6_reach_pass2", 64'((iss_n - ib) >= 9), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s6_busy",      64'(busy),      64'd0);
    chk("s6_res_valid", 64'(res_valid), 64'd0);
    chk("s6_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    a0 = a_cnt; rb = res_n;
    run_cmd(2, 2, 4);
    wait_idle(60);
    check_results("s6", a0, 2, 2, 4, rb);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
